// File: rtl/score_keeper.sv
// Flappy Bird score accumulator: 3-digit saturating BCD score, best-score commit at game
// over, registered active-low 7-segment drive. Define HIGH_SCORE_EN for best score + blinking display.
module score_keeper #(
  parameter int BLINK_BITS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        incr,
  input  logic        Stop,
  input  logic        newGame,
  output logic [11:0] score_bcd,
  output logic [11:0] best_bcd,
  output logic        gameOver,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0
);

  // state  | meaning
  // RUN    | game in play, score counts incr pulses
  // COMMIT | one cycle: best score updated from final score
  // OVER   | score frozen, display alternates score/best

  typedef enum logic [1:0] {RUN, COMMIT, OVER} state_t;

  state_t      state, state_nx;
  logic [11:0] score_nx;
  logic [11:0] score_inc;
  logic [11:0] disp;
  logic        show_best;

  if (BLINK_BITS < 1) begin : g_bad_blink
    $error("BLINK_BITS must be at least 1");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // BCD increment with carry, saturating at 999
  always_comb begin
    score_inc = score_bcd;
    if (score_bcd != 12'h999) begin
      if (score_bcd[3:0] != 4'd9) begin
        score_inc[3:0] = score_bcd[3:0] + 4'd1;
      end else begin
        score_inc[3:0] = 4'd0;
        if (score_bcd[7:4] != 4'd9) begin
          score_inc[7:4] = score_bcd[7:4] + 4'd1;
        end else begin
          score_inc[7:4]  = 4'd0;
          score_inc[11:8] = score_bcd[11:8] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    score_nx = score_bcd;
    case (state)
      RUN: begin
        if (newGame)   score_nx = 12'h000;
        else if (incr) score_nx = score_inc;
        if (Stop)      state_nx = COMMIT;
      end
      COMMIT: state_nx = OVER;
      OVER: begin
        if (newGame) begin
          score_nx = 12'h000;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      score_bcd <= 12'h000;
    end else begin
      state     <= state_nx;
      score_bcd <= score_nx;
    end
  end

  assign gameOver = (state == OVER);

`ifdef HIGH_SCORE_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  // BCD digits order the same as binary, so a plain magnitude compare suffices
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      best_bcd  <= 12'h000;
    end else if (state == COMMIT) begin
      blink_cnt <= '0;
      if (score_bcd > best_bcd) best_bcd <= score_bcd;
    end else if (state == OVER) begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign show_best = (state == OVER) && blink_cnt[BLINK_BITS-1];
`else
  assign best_bcd  = 12'h000;
  assign show_best = 1'b0;
`endif

  assign disp = show_best ? best_bcd : score_bcd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex2 <= 7'b1000000;
      hex1 <= 7'b1000000;
      hex0 <= 7'b1000000;
    end else begin
      hex2 <= seg7(disp[11:8]);
      hex1 <= seg7(disp[7:4]);
      hex0 <= seg7(disp[3:0]);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal behavioural model predicts each cycle's
// outputs, pushed when inputs are driven and popped after the clock edge.
module tb_score_keeper;

`ifdef HIGH_SCORE_EN
  localparam bit HSE = 1'b1;
`else
  localparam bit HSE = 1'b0;
`endif
  localparam int BB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        incr = 1'b0, Stop = 1'b0, newGame = 1'b0;
  logic [11:0] score_bcd, best_bcd;
  logic        gameOver;
  logic [6:0]  hex2, hex1, hex0;

  score_keeper #(.BLINK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .incr(incr), .Stop(Stop), .newGame(newGame),
    .score_bcd(score_bcd), .best_bcd(best_bcd), .gameOver(gameOver),
    .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] score;
    logic [11:0] best;
    logic        go;
    logic [20:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   m_state, m_score, m_best, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    seg = t[d];
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_best = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic step(input logic i, input logic s, input logic n);
    exp_t e, g;
    int   disp;
    incr = i; Stop = s; newGame = n;
    disp = (HSE && m_state == 2 && m_cnt >= 8) ? m_best : m_score;
    e.hex = {seg(disp / 100), seg((disp / 10) % 10), seg(disp % 10)};
    case (m_state)
      0: begin
        if (n) m_score = 0;
        else if (i && m_score < 999) m_score++;
        if (s) m_state = 1;
      end
      1: begin
        if (HSE && m_score > m_best) m_best = m_score;
        m_cnt = 0;
        m_state = 2;
      end
      default: begin
        m_cnt = (m_cnt + 1) % (1 << BB);
        if (n) begin m_score = 0; m_state = 0; end
      end
    endcase
    e.score = to_bcd(m_score);
    e.best  = to_bcd(m_best);
    e.go    = (m_state == 2);
    sb.push_back(e);
    @(posedge clk); #1;
    incr = 1'b0; Stop = 1'b0; newGame = 1'b0;
    g = sb.pop_front();
    check("score", score_bcd, g.score);
    check("best", best_bcd, g.best);
    check("gameOver", gameOver, g.go);
    check("hex", {hex2, hex1, hex0}, g.hex);
  endtask

  task automatic pulses(input int k);
    for (int j = 0; j < k; j++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_score", score_bcd, 12'h000);
    check("rst_best", best_bcd, 12'h000);
    check("rst_go", gameOver, 1'b0);
    check("rst_hex", {hex2, hex1, hex0}, {3{7'b1000000}});
    reset = 1'b1;
    @(posedge clk); #1;

    pulses(12);
    step(0, 0, 0);
    check("cnt12", score_bcd, 12'h012);
    check("cnt12_hex1", hex1, 7'b1111001);
    check("cnt12_hex0", hex0, 7'b0100100);

    pulses(87);
    check("cnt99", score_bcd, 12'h099);
    pulses(1);
    check("cnt100", score_bcd, 12'h100);
    pulses(899);
    check("cnt999", score_bcd, 12'h999);
    pulses(1);
    check("sat999", score_bcd, 12'h999);

    step(0, 0, 1);
    pulses(25);
    check("pre_stop", score_bcd, 12'h025);
    step(1, 1, 0);
    check("stop_incr", score_bcd, 12'h026);
    step(1, 0, 0);
    check("go_after2", gameOver, 1'b1);
    check("best26", best_bcd, HSE ? 12'h026 : 12'h000);
    for (int j = 0; j < 3; j++) step(1, 0, 0);
    check("frozen", score_bcd, 12'h026);

    step(0, 0, 1);
    check("newgame_score", score_bcd, 12'h000);
    check("newgame_go", gameOver, 1'b0);
    pulses(10);
    step(0, 1, 0);
    step(0, 0, 0);
    check("best_kept", best_bcd, HSE ? 12'h026 : 12'h000);
    for (int j = 0; j < 34; j++) step(0, 0, 0);

    step(0, 0, 1);
    pulses(5);
    step(0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_score", score_bcd, 12'h000);
    check("arst_best", best_bcd, 12'h000);
    check("arst_go", gameOver, 1'b0);
    check("arst_hex", {hex2, hex1, hex0}, {3{7'b1000000}});
    model_reset();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    pulses(3);
    check("resume", score_bcd, 12'h003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
